// File: rtl/dmem_access_unit_if.sv
// dmem_access_unit_if: core request/response and data-memory bus signals of the load/store unit.
interface dmem_access_unit_if;
    logic        req_rd;
    logic        req_wr;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        stall;
    logic [31:0] rdata;
    logic        err_misalign;
    logic        err_timeout;
    logic        bus_valid;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_ready;
    logic [31:0] bus_rdata;

    modport slave (
        input  req_rd, req_wr, req_addr, req_wdata, req_funct3, bus_ready, bus_rdata,
        output stall, rdata, err_misalign, err_timeout, bus_valid, bus_we, bus_addr, bus_wstrb, bus_wdata
    );
    modport master (
        output req_rd, req_wr, req_addr, req_wdata, req_funct3, bus_ready, bus_rdata,
        input  stall, rdata, err_misalign, err_timeout, bus_valid, bus_we, bus_addr, bus_wstrb, bus_wdata
    );
endinterface

// File: rtl/dmem_access_unit.sv
// dmem_access_unit: load/store unit bridging the core data port to a valid/ready memory bus,
// with byte-lane strobes, load extension, core stall, misalign and timeout flags.
module dmem_access_unit #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input logic clk,
    input logic rst,
    dmem_access_unit_if.slave io
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;

    state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0] data_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic        bus_valid_q, bus_we_q, err_timeout_q;
    logic [31:0] bus_addr_q, bus_wdata_q;
    logic [3:0]  bus_wstrb_q;

    logic        req, is_b, is_h, misalign;
    logic [3:0]  strb;
    logic [31:0] wdata, ext;
    logic [7:0]  lb;
    logic [15:0] lh;

    assign req      = io.req_rd | io.req_wr;
    assign is_b     = io.req_funct3[1:0] == 2'b00;
    assign is_h     = io.req_funct3[1:0] == 2'b01;
    // Anything that is not B/H (including the undefined encodings) is a word access.
    assign misalign = req & ((is_h & io.req_addr[0]) | (~is_b & ~is_h & |io.req_addr[1:0]));
    assign strb     = ~io.req_wr ? 4'b0000 :
                      is_b ? 4'b0001 << io.req_addr[1:0] :
                      is_h ? 4'b0011 << {io.req_addr[1], 1'b0} : 4'b1111;
    assign wdata    = is_b ? {4{io.req_wdata[7:0]}} :
                      is_h ? {2{io.req_wdata[15:0]}} : io.req_wdata;

    assign lb  = data_q[{off_q, 3'b000} +: 8];
    assign lh  = off_q[1] ? data_q[31:16] : data_q[15:0];
    assign ext = f3_q[1:0] == 2'b00 ? {{24{~f3_q[2] & lb[7]}}, lb} :
                 f3_q[1:0] == 2'b01 ? {{16{~f3_q[2] & lh[15]}}, lh} : data_q;

    assign io.rdata        = state_q == DONE ? ext : 32'h0;
    assign io.stall        = req & ~misalign & (state_q != DONE);
    assign io.err_misalign = misalign;
    assign io.err_timeout  = err_timeout_q;
    assign io.bus_valid    = bus_valid_q;
    assign io.bus_we       = bus_we_q;
    assign io.bus_addr     = bus_addr_q;
    assign io.bus_wstrb    = bus_wstrb_q;
    assign io.bus_wdata    = bus_wdata_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            data_q        <= '0;
            f3_q          <= '0;
            off_q         <= '0;
            bus_valid_q   <= 1'b0;
            bus_we_q      <= 1'b0;
            bus_addr_q    <= '0;
            bus_wstrb_q   <= '0;
            bus_wdata_q   <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (req && !misalign) begin
                    bus_valid_q <= 1'b1;
                    bus_we_q    <= io.req_wr;
                    bus_addr_q  <= {io.req_addr[31:2], 2'b00};
                    bus_wstrb_q <= strb;
                    bus_wdata_q <= wdata;
                    f3_q        <= io.req_funct3;
                    off_q       <= io.req_addr[1:0];
                    cnt_q       <= '0;
                    state_q     <= WAIT;
                end
                WAIT: if (io.bus_ready) begin
                    data_q      <= bus_we_q ? 32'h0 : io.bus_rdata;
                    bus_valid_q <= 1'b0;
                    state_q     <= DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    data_q        <= '0;
                    bus_valid_q   <= 1'b0;
                    err_timeout_q <= 1'b1;
                    state_q       <= DONE;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                DONE: begin
                    cnt_q         <= '0;
                    err_timeout_q <= 1'b0;
                    state_q       <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_access_unit.sv
// tb_dmem_access_unit: scoreboard bench; driver pushes expected bus payload and core response,
// a negedge monitor pops and compares when the DUT presents them.
module tb_dmem_access_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_access_unit_if io();
    dmem_access_unit #(.TIMEOUT(16), .CNT_W(5)) dut (.clk(clk), .rst(rst), .io(io));

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } bus_t;
    typedef struct {
        logic [31:0] rdata;
        logic        chk;
        logic        to;
    } resp_t;

    bus_t  bus_q[$];
    resp_t resp_q[$];
    int    checks = 0;
    int    errors = 0;
    logic  prev_bv = 1'b0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin : monitor
        bus_t  b;
        resp_t r;
        if (io.bus_valid && !prev_bv) begin
            if (bus_q.size() == 0) begin
                errors++;
                $display("FAIL bus_unexpected got=%h expected=none", io.bus_addr);
            end else begin
                b = bus_q.pop_front();
                check("bus_addr", io.bus_addr, b.addr);
                check("bus_we", 32'(io.bus_we), 32'(b.we));
                check("bus_wstrb", 32'(io.bus_wstrb), 32'(b.strb));
                if (b.we) check("bus_wdata", io.bus_wdata, b.wdata);
            end
        end
        prev_bv = io.bus_valid;
        if ((io.req_rd | io.req_wr) && !io.err_misalign && !io.stall) begin
            if (resp_q.size() == 0) begin
                errors++;
                $display("FAIL resp_unexpected got=%h expected=none", io.rdata);
            end else begin
                r = resp_q.pop_front();
                if (r.chk) check("rdata", io.rdata, r.rdata);
                check("err_timeout", 32'(io.err_timeout), 32'(r.to));
            end
        end
    end

    task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                          input logic [2:0] f3, input int lat, input logic [31:0] word,
                          input logic [31:0] exp_rdata, input logic chk, input logic to,
                          input logic [3:0] strb, input logic [31:0] bwd, input int exp_stall);
        int  ws, st;
        bit  done;
        bus_q.push_back('{{a[31:2], 2'b00}, wr, strb, bwd});
        resp_q.push_back('{exp_rdata, chk, to});
        io.req_rd = rd; io.req_wr = wr; io.req_addr = a; io.req_wdata = wd; io.req_funct3 = f3;
        ws = 0; st = 0; done = 0;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            if (io.bus_valid) begin
                ws++;
                if (ws == lat) begin
                    io.bus_ready = 1'b1;
                    io.bus_rdata = word;
                end
            end
            if (io.stall) st++;
            else done = 1;
            @(posedge clk); #1;
            io.bus_ready = 1'b0;
        end
        if (!done) begin
            errors++;
            $display("FAIL access_bound got=stuck expected=done addr=%h", a);
        end
        check("stall_cycles", 32'(st), 32'(exp_stall));
        check("valid_cycles", 32'(ws), lat == 0 ? 32'd16 : 32'(lat));
        io.req_rd = 1'b0; io.req_wr = 1'b0;
    endtask

    task automatic misal(input logic rd, input logic wr, input logic [31:0] a, input logic [2:0] f3);
        io.req_rd = rd; io.req_wr = wr; io.req_addr = a; io.req_wdata = 32'hFFFF_FFFF; io.req_funct3 = f3;
        @(negedge clk);
        check("mis_flag", 32'(io.err_misalign), 32'd1);
        check("mis_stall", 32'(io.stall), 32'd0);
        check("mis_rdata", io.rdata, 32'h0);
        @(posedge clk); #1;
        check("mis_valid", 32'(io.bus_valid), 32'd0);
        io.req_rd = 1'b0; io.req_wr = 1'b0;
    endtask

    initial begin
        io.req_rd = 0; io.req_wr = 0; io.req_addr = 0; io.req_wdata = 0; io.req_funct3 = 0;
        io.bus_ready = 0; io.bus_rdata = 0;
        #2 rst = 1'b0;
        @(negedge clk);
        check("rst_valid", 32'(io.bus_valid), 32'd0);
        check("rst_we", 32'(io.bus_we), 32'd0);
        check("rst_addr", io.bus_addr, 32'h0);
        check("rst_wstrb", 32'(io.bus_wstrb), 32'd0);
        check("rst_wdata", io.bus_wdata, 32'h0);
        check("rst_rdata", io.rdata, 32'h0);
        check("rst_timeout", 32'(io.err_timeout), 32'd0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        //     rd wr addr          wdata         f3      lat word          exp_rdata     chk to strb     bus_wdata     stall
        access(1, 0, 32'h100, 32'h0, 3'b010, 2, 32'hDEADBEEF, 32'hDEADBEEF, 1, 0, 4'b0000, 32'h0, 3);
        access(1, 0, 32'h103, 32'h0, 3'b000, 1, 32'h80112233, 32'hFFFFFF80, 1, 0, 4'b0000, 32'h0, 2);
        access(1, 0, 32'h103, 32'h0, 3'b100, 1, 32'h80112233, 32'h00000080, 1, 0, 4'b0000, 32'h0, 2);
        access(1, 0, 32'h102, 32'h0, 3'b001, 1, 32'h80112233, 32'hFFFF8011, 1, 0, 4'b0000, 32'h0, 2);
        access(1, 0, 32'h102, 32'h0, 3'b101, 3, 32'h80112233, 32'h00008011, 1, 0, 4'b0000, 32'h0, 4);
        access(1, 0, 32'h100, 32'h0, 3'b000, 1, 32'h80112233, 32'h00000033, 1, 0, 4'b0000, 32'h0, 2);
        access(1, 0, 32'h101, 32'h0, 3'b000, 1, 32'h00007F00, 32'h0000007F, 1, 0, 4'b0000, 32'h0, 2);
        access(1, 0, 32'h108, 32'h0, 3'b011, 1, 32'h89ABCDEF, 32'h89ABCDEF, 1, 0, 4'b0000, 32'h0, 2);
        access(0, 1, 32'h201, 32'hA5, 3'b000, 1, 32'h0, 32'h0, 0, 0, 4'b0010, 32'hA5A5A5A5, 2);
        access(0, 1, 32'h202, 32'h1234BEEF, 3'b001, 2, 32'h0, 32'h0, 0, 0, 4'b1100, 32'hBEEFBEEF, 3);
        access(0, 1, 32'h204, 32'h12345678, 3'b010, 1, 32'h0, 32'h0, 0, 0, 4'b1111, 32'h12345678, 2);
        access(1, 1, 32'h300, 32'h5A, 3'b000, 1, 32'h0, 32'h0, 0, 0, 4'b0001, 32'h5A5A5A5A, 2);
        misal(1, 0, 32'h102, 3'b010);
        misal(0, 1, 32'h203, 3'b001);
        misal(1, 0, 32'h101, 3'b101);
        misal(1, 0, 32'h10A, 3'b111);
        access(1, 0, 32'h400, 32'h0, 3'b010, 0, 32'h0, 32'h0, 1, 1, 4'b0000, 32'h0, 17);
        access(1, 0, 32'h104, 32'h0, 3'b010, 1, 32'h0BADF00D, 32'h0BADF00D, 1, 0, 4'b0000, 32'h0, 2);
        // Reset asserted while the bus request is outstanding.
        bus_q.push_back('{32'h600, 1'b0, 4'b0000, 32'h0});
        io.req_rd = 1'b1; io.req_addr = 32'h600; io.req_funct3 = 3'b010;
        @(posedge clk); #1;
        @(negedge clk);
        check("wait_valid", 32'(io.bus_valid), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("arst_valid", 32'(io.bus_valid), 32'd0);
        check("arst_rdata", io.rdata, 32'h0);
        io.req_rd = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        access(1, 0, 32'h500, 32'h0, 3'b010, 1, 32'hCAFEF00D, 32'hCAFEF00D, 1, 0, 4'b0000, 32'h0, 2);
        repeat (2) @(posedge clk);
        check("bus_q_left", 32'(bus_q.size()), 32'd0);
        check("resp_q_left", 32'(resp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
